neopix_frame_sched: RTL and testbench

- Owns the LED colour state for the breakout neopixel chain and shares it between several status sources.
- Requesters write individual LED colours into a staging buffer through a round-robin arbiter.
- A fixed-rate frame scheduler copies staging to a display buffer, applying brightness and mode at copy time, then pulses the ws2811 driver to start a refresh.
- Sits between the status/button/IO logic and the ws2811 driver. The driver reads the display buffer by address.

---
 rtl/neopix_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/neopix_frame_sched.sv | 163 ++++++++++++++++
 tb/tb_neopix_frame_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopix_pkg.sv
// Shared encodings and helpers for the neopixel frame scheduler.
// Mode, state and colour constants used by the scheduler and its requesters.
package neopix_pkg;

  localparam int ADDR_W = 6;
  localparam int RGB_W  = 24;

  // Mode value 3 is not named: it behaves exactly like MODE_NORMAL.
  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_OFF    = 2'd1,
    MODE_BLINK  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [RGB_W-1:0] COL_OFF  = 24'h000000;
  localparam logic [RGB_W-1:0] COL_RED  = 24'hFF0000;
  localparam logic [RGB_W-1:0] COL_ORG  = 24'hFF8000;
  localparam logic [RGB_W-1:0] COL_YEL  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] COL_GRN  = 24'h00FF00;
  localparam logic [RGB_W-1:0] COL_CYN  = 24'h00FFFF;
  localparam logic [RGB_W-1:0] COL_LBLU = 24'h0080FF;
  localparam logic [RGB_W-1:0] COL_BLU  = 24'h0000FF;
  localparam logic [RGB_W-1:0] COL_PURP = 24'h8000FF;
  localparam logic [RGB_W-1:0] COL_PINK = 24'hFF00FF;

  // Brightness: (c * (lvl+1)) >> 8, so level 255 is identity and level 0 is dark.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] lvl);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, lvl} + 17'd1);
    return 8'(prod >> 8);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, searching upward from the pointer.
// Pointer advances to winner+1 on a granted cycle and holds otherwise; enable=0 forces no grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    logic found;
    int   idx;
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && enable && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = PTR_W'((idx + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/neopix_frame_sched.sv
// LED colour owner: arbitrated writes into staging, per-frame scaled copy into display, driver read port.
// Writes land on the grant edge; copy takes NUM_LEDS cycles then one frame_start cycle; reads have 1-cycle latency.
module neopix_frame_sched
  import neopix_pkg::*;
#(
  parameter int NUM_LEDS     = 41,
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 833_333,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*RGB_W-1:0]  i_rgb,
  output logic [NUM_REQ-1:0]        o_grant,
  input  logic [7:0]                i_ledlevel,
  input  logic [1:0]                i_ledmode,
  input  logic [ADDR_W-1:0]         i_rd_addr,
  output logic [7:0]                o_red,
  output logic [7:0]                o_green,
  output logic [7:0]                o_blue,
  output logic                      o_frame_start,
  output logic                      o_err_addr
);

  localparam int FC_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int LIM_W = ADDR_W + 1;
  localparam logic [LIM_W-1:0]  LED_LIM  = LIM_W'(NUM_LEDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

  state_t state, state_next;

  logic [FC_W-1:0]   frame_cnt;
  logic [BF_W-1:0]   blink_cnt;
  logic              blink_phase;
  logic [ADDR_W-1:0] copy_idx;
  logic              tick;

  logic [RGB_W-1:0]  staging [NUM_LEDS];
  logic [RGB_W-1:0]  display [NUM_LEDS];

  logic              wr_en;
  logic              wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [RGB_W-1:0]  wr_rgb;
  logic [RGB_W-1:0]  stg_pix;
  logic [RGB_W-1:0]  out_pix;

  assign tick = (frame_cnt == FC_W'(FRAME_CYCLES - 1));

  // Reset gates the enable so the grant drops the moment reset rises.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (i_clk),
    .rst    (i_reset),
    .req    (i_req),
    .enable ((state == IDLE) && !i_reset),
    .grant  (o_grant)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_rgb  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (o_grant[k]) begin
        wr_en   = 1'b1;
        wr_addr = i_addr[k*ADDR_W +: ADDR_W];
        wr_rgb  = i_rgb[k*RGB_W +: RGB_W];
      end
    end
    wr_ok = ({1'b0, wr_addr} < LED_LIM);
  end

  always_ff @(posedge i_clk) begin
    if (wr_en && wr_ok) begin
      staging[wr_addr] <= wr_rgb;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_err_addr <= 1'b0;
    end else if (wr_en && !wr_ok) begin
      o_err_addr <= 1'b1;
    end
  end

  // Level and mode are taken live for each LED as it is copied.
  always_comb begin
    stg_pix = staging[copy_idx];
    out_pix = {scale8(stg_pix[23:16], i_ledlevel),
               scale8(stg_pix[15:8],  i_ledlevel),
               scale8(stg_pix[7:0],   i_ledlevel)};
    if ((i_ledmode == MODE_OFF) || ((i_ledmode == MODE_BLINK) && blink_phase)) begin
      out_pix = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == COPY) begin
      display[copy_idx] <= out_pix;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      {o_red, o_green, o_blue} <= '0;
    end else if ({1'b0, i_rd_addr} < LED_LIM) begin
      {o_red, o_green, o_blue} <= display[i_rd_addr];
    end else begin
      {o_red, o_green, o_blue} <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    o_frame_start = 1'b0;
    case (state)
      IDLE: if (tick) state_next = COPY;
      COPY: if (copy_idx == LAST_IDX) state_next = DONE;
      DONE: begin
        o_frame_start = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      frame_cnt   <= '0;
      copy_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      frame_cnt <= tick ? '0 : frame_cnt + 1'b1;
      case (state)
        COPY: copy_idx <= copy_idx + 1'b1;
        DONE: begin
          copy_idx <= '0;
          if (blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
        default: copy_idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_neopix_frame_sched.sv
// Bench for neopix_frame_sched: randomized writes checked against an array model of staging/display.
// Short frame period so many frames fit in one run.
module tb_neopix_frame_sched;
  import neopix_pkg::*;

  localparam int N = 41;
  localparam int R = 4;
  localparam int F = 200;
  localparam int B = 2;
  localparam int WAIT_MAX = 2 * F + N + 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [R-1:0]  req = '0;
  logic [R*6-1:0]  addr = '0;
  logic [R*24-1:0] rgb = '0;
  logic [R-1:0]  grant;
  logic [7:0]    level = 8'd255;
  logic [1:0]    mode = 2'd0;
  logic [5:0]    rd_addr = '0;
  logic [7:0]    red, green, blue;
  logic          frame_start;
  logic          err_addr;

  int checks = 0;
  int errors = 0;
  int frame_num = 0;
  logic [23:0] stage_m [N];
  logic [23:0] disp_m  [N];
  logic [23:0] palette [10];

  neopix_frame_sched #(
    .NUM_LEDS(N), .NUM_REQ(R), .FRAME_CYCLES(F), .BLINK_FRAMES(B)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_addr(addr), .i_rgb(rgb),
    .o_grant(grant), .i_ledlevel(level), .i_ledmode(mode), .i_rd_addr(rd_addr),
    .o_red(red), .o_green(green), .o_blue(blue),
    .o_frame_start(frame_start), .o_err_addr(err_addr)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [23:0] model_pix(input logic [23:0] c, input int lvl, input int md, input int ph);
    int r, g, b;
    if (md == 1 || (md == 2 && ph == 1)) return 24'h0;
    r = int'(c[23:16]) * (lvl + 1) / 256;
    g = int'(c[15:8])  * (lvl + 1) / 256;
    b = int'(c[7:0])   * (lvl + 1) / 256;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  // Reference model: granted writes land in staging; each frame_start snapshots staging into display.
  initial begin
    for (int j = 0; j < N; j++) begin
      stage_m[j] = 24'h0;
      disp_m[j]  = 24'h0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        frame_num = 0;
      end else begin
        for (int k = 0; k < R; k++)
          if (grant[k] && int'(addr[6*k +: 6]) < N)
            stage_m[addr[6*k +: 6]] = rgb[24*k +: 24];
        if (frame_start) begin
          frame_num++;
          for (int j = 0; j < N; j++)
            disp_m[j] = model_pix(stage_m[j], int'(level), int'(mode), ((frame_num - 1) / B) % 2);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req = '0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_frame(output int cyc);
    cyc = -1;
    for (int n = 1; n <= WAIT_MAX; n++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        cyc = n;
        break;
      end
    end
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL frame_timeout: no frame_start within %0d cycles, required one", WAIT_MAX);
    end
  endtask

  task automatic write_led(input int k, input int a, input logic [23:0] c);
    bit got;
    got = 1'b0;
    @(negedge clk);
    req[k] = 1'b1; addr[6*k +: 6] = 6'(a); rgb[24*k +: 24] = c;
    for (int n = 0; n < WAIT_MAX; n++) begin
      @(negedge clk);
      if (grant[k]) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout: requester %0d got no grant, required one", k);
    end
    @(posedge clk); #1 req[k] = 1'b0;
  endtask

  task automatic read_led(input int a, output logic [23:0] v);
    @(negedge clk); rd_addr = 6'(a);
    @(negedge clk); v = {red, green, blue};
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; req = '1;
    @(negedge clk);
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b, required 0000", grant); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b, required 0", frame_start); end
    checks++; if ({red, green, blue} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h, required 000000", {red, green, blue}); end
    checks++; if (err_addr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err_addr); end
    req = '0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_first_frame();
    int cyc;
    logic [23:0] v;
    wait_frame(cyc);
    checks++;
    if (cyc != F + N) begin errors++; $display("FAIL first_frame_time: got %0d edges, required %0d", cyc, F + N); end
    @(negedge clk);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_pulse_width: got %b, required 0", frame_start); end
    for (int j = 0; j < N; j++) begin
      read_led(j, v);
      checks++;
      if (v !== 24'h0) begin errors++; $display("FAIL first_frame_led%0d: got %h, required 000000", j, v); end
    end
    read_led(50, v);
    checks++; if (v !== 24'h0) begin errors++; $display("FAIL read_oob: got %h, required 000000", v); end
  endtask

  task automatic test_single_write();
    int cyc;
    logic [23:0] v;
    write_led(0, 5, 24'h1A0000);
    wait_frame(cyc);
    read_led(5, v);
    checks++; if (v[23:16] !== 8'h1A) begin errors++; $display("FAIL single_red_l255: got %h, required 1a", v[23:16]); end
    checks++; if (v !== disp_m[5]) begin errors++; $display("FAIL single_pix_l255: got %h, required %h", v, disp_m[5]); end
    level = 8'd127;
    wait_frame(cyc);
    read_led(5, v);
    checks++; if (v[23:16] !== 8'h0D) begin errors++; $display("FAIL single_red_l127: got %h, required 0d", v[23:16]); end
    read_led(4, v);
    checks++; if (v !== disp_m[4]) begin errors++; $display("FAIL neighbour_led4: got %h, required %h", v, disp_m[4]); end
  endtask

  task automatic test_rotation();
    int cyc, last, gap, n_gaps, w;
    logic [23:0] v;
    wait_frame(cyc);
    level = 8'($urandom_range(1, 254));
    mode  = 2'd3;
    @(negedge clk);
    for (int k = 0; k < R; k++) begin
      addr[6*k +: 6]  = 6'($urandom_range(0, N - 1));
      rgb[24*k +: 24] = ($urandom_range(0, 1) != 0) ? palette[$urandom_range(0, 9)] : 24'($urandom);
    end
    req = '1;
    last = -1; gap = 0; n_gaps = 0;
    for (int c = 0; c < 3 * F; c++) begin
      @(negedge clk);
      if (grant == '0) begin
        gap++;
      end else begin
        w = $clog2(int'(grant));
        checks++;
        if (!$onehot(grant)) begin errors++; $display("FAIL rot_onehot: got %b, required one-hot", grant); end
        if (last >= 0) begin
          checks++;
          if (w != (last + 1) % R) begin errors++; $display("FAIL rot_order: got %0d, required %0d", w, (last + 1) % R); end
          if (gap != 0) begin
            n_gaps++;
            checks++;
            if (gap != N + 1) begin errors++; $display("FAIL rot_gap: got %0d idle cycles, required %0d", gap, N + 1); end
          end
        end
        last = w; gap = 0;
        @(posedge clk); #1;
        addr[6*w +: 6]  = 6'($urandom_range(0, N - 1));
        rgb[24*w +: 24] = 24'($urandom);
      end
    end
    req = '0;
    checks++;
    if (n_gaps < 2) begin errors++; $display("FAIL rot_gap_count: got %0d gaps, required >= 2", n_gaps); end
    wait_frame(cyc);
    for (int j = 0; j < N; j++) begin
      read_led(j, v);
      checks++;
      if (v !== disp_m[j]) begin errors++; $display("FAIL rot_led%0d: got %h, required %h", j, v, disp_m[j]); end
    end
  endtask

  task automatic test_err_addr();
    int cyc;
    logic [23:0] v;
    write_led(1, 45, 24'($urandom));
    checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL err_set: got %b, required 1", err_addr); end
    wait_frame(cyc);
    for (int j = 0; j < N; j++) begin
      read_led(j, v);
      checks++;
      if (v !== disp_m[j]) begin errors++; $display("FAIL err_led%0d: got %h, required %h", j, v, disp_m[j]); end
    end
    checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, required 1", err_addr); end
    do_reset();
    checks++; if (err_addr !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b, required 0", err_addr); end
  endtask

  task automatic test_blink();
    int cyc;
    logic [23:0] v;
    level = 8'd255;
    mode  = 2'd2;
    write_led(2, 0, 24'h000813);
    for (int f = 1; f <= 6; f++) begin
      wait_frame(cyc);
      read_led(0, v);
      checks++;
      if (v !== disp_m[0]) begin errors++; $display("FAIL blink_f%0d: got %h, required %h", f, v, disp_m[0]); end
    end
    mode = 2'd1;
    for (int f = 1; f <= 2; f++) begin
      wait_frame(cyc);
      read_led(0, v);
      checks++;
      if (v !== 24'h0) begin errors++; $display("FAIL mode_off_f%0d: got %h, required 000000", f, v); end
    end
  endtask

  task automatic test_reset_mid_copy();
    int cyc;
    logic [23:0] v;
    mode  = 2'd0;
    level = 8'($urandom_range(1, 254));
    do_reset();
    for (int j = 0; j < N; j++) write_led(0, j, 24'($urandom));
    wait_frame(cyc);
    for (int j = 0; j < N; j++) write_led(3, j, 24'($urandom) | 24'h010101);
    do_reset();
    repeat (F + 20) @(posedge clk);
    #1 rst = 1'b1;
    req[0] = 1'b1; addr[5:0] = 6'd0; rgb[23:0] = 24'hABCDEF;
    #1;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL midcopy_grant: got %b, required 0000", grant); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL midcopy_frame_start: got %b, required 0", frame_start); end
    for (int j = 0; j < 20; j++) disp_m[j] = model_pix(stage_m[j], int'(level), int'(mode), 0);
    @(negedge clk); req = '0;
    @(negedge clk); rst = 1'b0;
    for (int j = 0; j < N; j++) begin
      read_led(j, v);
      checks++;
      if (v !== disp_m[j]) begin errors++; $display("FAIL partial_led%0d: got %h, required %h", j, v, disp_m[j]); end
    end
    wait_frame(cyc);
    for (int j = 0; j < N; j++) begin
      read_led(j, v);
      checks++;
      if (v !== disp_m[j]) begin errors++; $display("FAIL full_led%0d: got %h, required %h", j, v, disp_m[j]); end
    end
  endtask

  initial begin
    palette = '{COL_OFF, COL_RED, COL_ORG, COL_YEL, COL_GRN,
                COL_CYN, COL_LBLU, COL_BLU, COL_PURP, COL_PINK};
    test_reset();
    test_first_frame();
    test_single_write();
    test_rotation();
    test_err_addr();
    test_blink();
    test_reset_mid_copy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
